// File: rtl/guess_entry.sv
// guess_entry: debounces ENTER, captures the switch word, validates 4 distinct digits and offers it over valid/ready.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int ERR_FLASH_CYCLES = 50_000_000,
  parameter int DIGIT_MAX        = 9
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enter_btn,
  input  logic [15:0]     sw,
  input  logic            guess_ready,
  output logic            guess_valid,
  output logic [3:0][3:0] guess,
  output logic            err_pulse,
  output logic            err_led,
  output logic [7:0]      entry_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(ERR_FLASH_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_INIT = FW'(ERR_FLASH_CYCLES);
  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);
  typedef enum logic [1:0] {IDLE, CHECK, OFFER, ERROR} state_t;
  state_t state, state_d;
  logic [1:0] btn_s;
  logic [15:0] sw_s1, sw_s2;
  logic deb, deb_q, press, legal, load, chk_fail;
  logic [DW-1:0] db_cnt;
  logic [FW-1:0] flash;
  assign press = deb & ~deb_q;
  assign guess_valid = state == OFFER;
  assign err_led = flash != '0;
  assign chk_fail = state == CHECK && !legal;
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (guess[i] > DMAX) legal = 1'b0;
      for (int j = i + 1; j < 4; j++)
        if (guess[i] == guess[j]) legal = 1'b0;
    end
  end
  always_comb begin
    state_d = state;
    load = 1'b0;
    case (state)
      IDLE: begin
        load = press;
        state_d = press ? CHECK : IDLE;
      end
      CHECK: state_d = legal ? OFFER : ERROR;
      OFFER: state_d = guess_ready ? IDLE : OFFER;
      default: begin
        load = press;
        state_d = press ? CHECK : (flash == '0) ? IDLE : ERROR;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      deb <= 1'b0;
      deb_q <= 1'b0;
      db_cnt <= '0;
      guess <= '0;
      err_pulse <= 1'b0;
      flash <= '0;
      entry_count <= '0;
    end else begin
      btn_s <= {btn_s[0], enter_btn};
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      deb_q <= deb;
      if (btn_s[1] == deb) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        deb <= btn_s[1];
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
      if (load) guess <= sw_s2;
      err_pulse <= chk_fail;
      // a press during ERROR cancels the flash; outside ERROR the counter idles at 0
      flash <= chk_fail ? FLASH_INIT : (state == ERROR && !press && flash != '0) ? flash - 1'b1 : '0;
      if (guess_valid && guess_ready) entry_count <= entry_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: table-driven and randomized transaction-level checks of guess_entry.
module tb_guess_entry;
  logic clock = 1'b0, reset = 1'b1, enter_btn = 1'b0, guess_ready = 1'b1;
  logic [15:0] sw = '0;
  logic guess_valid, err_pulse, err_led;
  logic [15:0] guess;
  logic [7:0] entry_count;
  int vectors = 0, miscompares = 0;
  int n_xfer = 0, n_pulse = 0, n_led = 0;
  logic [15:0] last_guess = '0;
  int model_cnt = 0;

  guess_entry #(.DEBOUNCE_CYCLES(4), .ERR_FLASH_CYCLES(8), .DIGIT_MAX(9)) dut (
    .clock(clock), .reset(reset), .enter_btn(enter_btn), .sw(sw), .guess_ready(guess_ready),
    .guess_valid(guess_valid), .guess(guess), .err_pulse(err_pulse), .err_led(err_led),
    .entry_count(entry_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (!reset) begin
    if (guess_valid && guess_ready) begin
      n_xfer++;
      last_guess = guess;
    end
    if (err_pulse) n_pulse++;
    if (err_led) n_led++;
  end

  typedef struct {
    logic [15:0] w;
    bit legal;
    int hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic bit legal_ref(input logic [15:0] w);
    bit seen[16];
    logic [3:0] d;
    foreach (seen[k]) seen[k] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = w[4*k +: 4];
      if (d > 4'd9 || seen[d]) return 1'b0;
      seen[d] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic trial(input logic [15:0] w, input bit legal, input int hold, input bit rand_ready);
    int x0, p0, l0;
    x0 = n_xfer; p0 = n_pulse; l0 = n_led;
    sw = w;
    enter_btn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == hold) enter_btn = 1'b0;
      if (rand_ready) guess_ready = $urandom_range(0, 3) != 0;
      tick(1);
    end
    guess_ready = 1'b1;
    if (legal) model_cnt++;
    chk($sformatf("xfer %h", w), n_xfer - x0, {31'b0, legal});
    if (legal) chk($sformatf("guess %h", w), {16'b0, last_guess}, {16'b0, w});
    chk($sformatf("pulse %h", w), n_pulse - p0, {31'b0, !legal});
    chk($sformatf("led %h", w), n_led - l0, legal ? 0 : 8);
    chk($sformatf("count %h", w), {24'b0, entry_count}, model_cnt % 256);
  endtask

  initial begin
    vec_t tbl[$];
    int x0, guard;
    logic [15:0] w;
    int d[10];
    tbl = '{'{16'h1234, 1, 10}, '{16'h1123, 0, 8}, '{16'h12A4, 0, 8}, '{16'h9870, 1, 8},
            '{16'h0000, 0, 8}, '{16'h0123, 1, 8}, '{16'hF012, 0, 8}, '{16'h1231, 0, 8},
            '{16'h9876, 1, 12}};
    tick(3);
    chk("rst valid", {31'b0, guess_valid}, 0);
    chk("rst guess", {16'b0, guess}, 0);
    chk("rst pulse", {31'b0, err_pulse}, 0);
    chk("rst led", {31'b0, err_led}, 0);
    chk("rst count", {24'b0, entry_count}, 0);
    reset = 1'b0;
    tick(2);
    foreach (tbl[i]) trial(tbl[i].w, tbl[i].legal, tbl[i].hold, 1'b0);

    // bouncy press then bouncy release: one transfer
    x0 = n_xfer;
    sw = 16'h5678;
    for (int i = 0; i < 6; i++) begin enter_btn = ~enter_btn; tick(2); end
    enter_btn = 1'b1;
    tick(10);
    for (int i = 0; i < 5; i++) begin enter_btn = ~enter_btn; tick(2); end
    tick(30);
    model_cnt++;
    chk("bounce xfer", n_xfer - x0, 1);
    chk("bounce guess", {16'b0, last_guess}, 32'h5678);
    chk("bounce count", {24'b0, entry_count}, model_cnt % 256);

    // backpressure: second press during OFFER is lost
    x0 = n_xfer;
    guess_ready = 1'b0;
    sw = 16'h1234;
    enter_btn = 1'b1; tick(8); enter_btn = 1'b0; tick(10);
    chk("bp valid", {31'b0, guess_valid}, 1);
    chk("bp guess", {16'b0, guess}, 32'h1234);
    sw = 16'h5678;
    enter_btn = 1'b1; tick(8); enter_btn = 1'b0; tick(12);
    chk("bp hold valid", {31'b0, guess_valid}, 1);
    chk("bp hold guess", {16'b0, guess}, 32'h1234);
    guess_ready = 1'b1;
    tick(30);
    model_cnt++;
    chk("bp xfer", n_xfer - x0, 1);
    chk("bp last", {16'b0, last_guess}, 32'h1234);
    chk("bp idle", {31'b0, guess_valid}, 0);
    chk("bp count", {24'b0, entry_count}, model_cnt % 256);

    // async reset during the error flash
    sw = 16'h1123;
    enter_btn = 1'b1; tick(11);
    chk("err led on", {31'b0, err_led}, 1);
    #1 reset = 1'b1;
    #1 chk("rst err led", {31'b0, err_led}, 0);
    enter_btn = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(10);

    // async reset mid-OFFER
    guess_ready = 1'b0;
    sw = 16'h2468;
    enter_btn = 1'b1; tick(8); enter_btn = 1'b0; tick(10);
    chk("pre-rst valid", {31'b0, guess_valid}, 1);
    #1 reset = 1'b1;
    #1;
    chk("async valid", {31'b0, guess_valid}, 0);
    chk("async count", {24'b0, entry_count}, 0);
    chk("async led", {31'b0, err_led}, 0);
    tick(2);
    reset = 1'b0;
    guess_ready = 1'b1;
    model_cnt = 0;
    tick(2);
    trial(16'h4321, 1'b1, 8, 1'b0);

    // randomized words and ready until the counter wraps
    guard = 0;
    while (model_cnt < 256 && guard < 3000) begin
      guard++;
      if ($urandom_range(0, 9) < 7) begin
        for (int k = 0; k < 10; k++) d[k] = k;
        for (int k = 9; k > 0; k--) begin
          int r, t;
          r = $urandom_range(0, k);
          t = d[k]; d[k] = d[r]; d[r] = t;
        end
        w = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
      end else w = 16'($urandom);
      trial(w, legal_ref(w), $urandom_range(7, 12), 1'b1);
    end
    chk("wrap count", {24'b0, entry_count}, 0);
    chk("wrap reached", model_cnt, 256);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
